// File: rtl/fault_pkg.sv
// Purpose : shared types and helpers for the fault-injection campaign sequencer.
// Latency : n/a (types and combinational functions only).
// Backpressure: n/a.
// Contents: state_t FSM encoding, mk_burst_mask (rotated contiguous mask), popcount.
package fault_pkg;

   // Helpers work on a fixed wide vector; callers cast to their own width.
   localparam int FP_MAX_W     = 512;
   localparam int FP_IDX_W     = $clog2(FP_MAX_W);
   localparam int FP_MAX_BURST = 64;

   typedef enum logic [2:0] {
      IDLE,
      GOLD_GO,
      GOLD_WAIT,
      FAULT_GO,
      FAULT_WAIT,
      REPORT,
      NEXT,
      DONE
   } state_t;

   // Bits (loc+i) mod width for i in [0, len); the burst wraps from the top bit to bit 0.
   function automatic logic [FP_MAX_W-1:0] mk_burst_mask(input int loc, input int len, input int width);
      logic [FP_MAX_W-1:0] m;
      m = '0;
      for (int i = 0; i < FP_MAX_BURST; i++) begin
         if (i < len) m[FP_IDX_W'((loc + i) % width)] = 1'b1;
      end
      return m;
   endfunction

   function automatic int popcount(input logic [FP_MAX_W-1:0] v);
      int c;
      c = 0;
      for (int i = 0; i < FP_MAX_W; i++) c += int'(v[i]);
      return c;
   endfunction

endpackage

// File: rtl/fault_campaign_ctrl_hd.sv
// Purpose : Hamming-distance unit, population count of a difference vector.
// Latency : combinational; the parent registers the result.
// Backpressure: none.
// Ports   : din (DATA_W difference vector) -> hd ($clog2(DATA_W)+1 bit count).
module hd_popcount
   import fault_pkg::*;
#(
   parameter int DATA_W = 128
) (
   input  logic [DATA_W-1:0]       din,
   output logic [$clog2(DATA_W):0] hd
);

   assign hd = ($clog2(DATA_W)+1)'(popcount(FP_MAX_W'(din)));

endmodule

// File: rtl/fault_campaign_ctrl.sv
// Purpose : on-chip fault-injection sweep; per location runs the core clean then faulted and reports both.
// Latency : 2*(LATENCY+1)+2 cycles per location with res_ready high; first record 2*(LATENCY+1) cycles after start.
// Backpressure: res_ready low holds REPORT and every res_* output indefinitely; no record is dropped.
// Ports   : CLK_50/RST_N; start/abort/burst_len/loc_first/loc_last control; core_start/fault_en/fault_mask/core_out
//           to the cipher core; res_* valid/ready record stream; busy/done status; n_effective/n_total statistics.
module fault_campaign_ctrl
   import fault_pkg::*;
#(
   parameter int DATA_W    = 128,
   parameter int LOC_W     = $clog2(DATA_W),
   parameter int LATENCY   = 22,
   parameter int MAX_BURST = 8,
   parameter int CNT_W     = 16
) (
   input  logic                      CLK_50,
   input  logic                      RST_N,
   input  logic                      start,
   input  logic                      abort,
   input  logic [$clog2(MAX_BURST):0] burst_len,
   input  logic [LOC_W-1:0]          loc_first,
   input  logic [LOC_W-1:0]          loc_last,
   output logic                      core_start,
   output logic                      fault_en,
   output logic [DATA_W-1:0]         fault_mask,
   input  logic [DATA_W-1:0]         core_out,
   output logic                      res_valid,
   input  logic                      res_ready,
   output logic [LOC_W-1:0]          res_loc,
   output logic [DATA_W-1:0]         res_gold,
   output logic [DATA_W-1:0]         res_faulty,
   output logic [$clog2(DATA_W):0]   res_hd,
   output logic                      busy,
   output logic                      done,
   output logic [CNT_W-1:0]          n_effective,
   output logic [CNT_W-1:0]          n_total
);

   localparam int BL_W = $clog2(MAX_BURST) + 1;
   localparam int HD_W = $clog2(DATA_W) + 1;
   localparam int WC_W = $clog2(LATENCY + 1);

   state_t            state, state_nxt;
   logic [LOC_W-1:0]  loc, loc_last_q;
   logic [BL_W-1:0]   blen, blen_clamped;
   logic [WC_W-1:0]   wcnt;
   logic [DATA_W-1:0] gold, faulty;
   logic [HD_W-1:0]   hd_q, hd_nxt;
   logic [CNT_W-1:0]  n_eff_q, n_tot_q;
   logic              last_loc;

   always_comb begin
      blen_clamped = burst_len;
      if (burst_len == '0)
         blen_clamped = BL_W'(1);
      else if (burst_len > BL_W'(MAX_BURST))
         blen_clamped = BL_W'(MAX_BURST);
   end

   // Distance is taken against the live core output so the result is ready on REPORT entry.
   hd_popcount #(.DATA_W(DATA_W)) u_hd (
      .din (gold ^ core_out),
      .hd  (hd_nxt)
   );

   assign last_loc = (loc == loc_last_q) || abort;

   always_ff @(posedge CLK_50 or negedge RST_N) begin
      if (!RST_N) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      core_start = 1'b0;
      fault_en   = 1'b0;
      res_valid  = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = GOLD_GO;
         end
         GOLD_GO: begin
            core_start = 1'b1;
            state_nxt  = GOLD_WAIT;
         end
         GOLD_WAIT: begin
            if (wcnt == '0) state_nxt = FAULT_GO;
         end
         FAULT_GO: begin
            core_start = 1'b1;
            fault_en   = 1'b1;
            state_nxt  = FAULT_WAIT;
         end
         FAULT_WAIT: begin
            fault_en = 1'b1;
            if (wcnt == '0) state_nxt = REPORT;
         end
         REPORT: begin
            res_valid = 1'b1;
            if (res_ready) state_nxt = NEXT;
         end
         NEXT: begin
            state_nxt = last_loc ? DONE : GOLD_GO;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK_50 or negedge RST_N) begin
      if (!RST_N) begin
         loc        <= '0;
         loc_last_q <= '0;
         blen       <= '0;
         wcnt       <= '0;
         gold       <= '0;
         faulty     <= '0;
         hd_q       <= '0;
         n_eff_q    <= '0;
         n_tot_q    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  loc        <= loc_first;
                  loc_last_q <= loc_last;
                  blen       <= blen_clamped;
                  n_eff_q    <= '0;
                  n_tot_q    <= '0;
               end
            end
            GOLD_GO, FAULT_GO: wcnt <= WC_W'(LATENCY - 1);
            GOLD_WAIT: begin
               if (wcnt == '0) gold <= core_out;
               else            wcnt <= wcnt - 1'b1;
            end
            FAULT_WAIT: begin
               if (wcnt == '0) begin
                  faulty <= core_out;
                  hd_q   <= hd_nxt;
               end else begin
                  wcnt <= wcnt - 1'b1;
               end
            end
            REPORT: begin
               // Statistics saturate rather than wrap.
               if (res_ready) begin
                  if (n_tot_q != '1) n_tot_q <= n_tot_q + 1'b1;
                  if ((hd_q != '0) && (n_eff_q != '1)) n_eff_q <= n_eff_q + 1'b1;
               end
            end
            NEXT: begin
               if (!last_loc) loc <= (loc == LOC_W'(DATA_W - 1)) ? '0 : loc + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Mask is derived from the registered location, so it is stable for the whole faulted run.
   assign fault_mask  = fault_en ? DATA_W'(mk_burst_mask(int'(loc), int'(blen), DATA_W)) : '0;
   assign res_loc     = loc;
   assign res_gold    = gold;
   assign res_faulty  = faulty;
   assign res_hd      = hd_q;
   assign n_effective = n_eff_q;
   assign n_total     = n_tot_q;

endmodule

// File: tb/tb_fault_campaign_ctrl.sv
module tb_fault_campaign_ctrl;

   localparam int DW  = 128;
   localparam int LW  = 7;
   localparam int HW  = 8;
   localparam int LAT = 22;
   localparam int CW  = 16;

   logic          clk = 1'b0;
   logic          rst_n, start, abort, res_ready;
   logic [3:0]    burst_len;
   logic [LW-1:0] loc_first, loc_last;
   logic          core_start, fault_en, res_valid, busy, done;
   logic [DW-1:0] fault_mask, core_out, res_gold, res_faulty;
   logic [LW-1:0] res_loc;
   logic [HW-1:0] res_hd;
   logic [CW-1:0] n_effective, n_total;

   logic          core_fault;
   logic [DW-1:0] core_const;
   logic [DW-1:0] pipe [LAT];

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [LW-1:0] loc;
      logic [DW-1:0] mask;
   } exp_t;

   typedef struct {
      int lf, ll, bl, fm, abort_after, ready_mode, stray, exp_total, exp_eff;
   } vec_t;

   always #5 clk = ~clk;

   fault_campaign_ctrl dut (
      .CLK_50(clk), .RST_N(rst_n), .start(start), .abort(abort), .burst_len(burst_len),
      .loc_first(loc_first), .loc_last(loc_last), .core_start(core_start), .fault_en(fault_en),
      .fault_mask(fault_mask), .core_out(core_out), .res_valid(res_valid), .res_ready(res_ready),
      .res_loc(res_loc), .res_gold(res_gold), .res_faulty(res_faulty), .res_hd(res_hd),
      .busy(busy), .done(done), .n_effective(n_effective), .n_total(n_total)
   );

   // Dummy core: result is valid exactly LATENCY cycles after core_start, garbage at any other time.
   always @(posedge clk) begin
      pipe[0] <= core_start ? ((core_fault && fault_en) ? fault_mask : '0)
                            : {$urandom, $urandom, $urandom, $urandom};
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign core_out = core_const ^ pipe[LAT-1];

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int clamp_len(input int bl);
      if (bl < 1) return 1;
      if (bl > 8) return 8;
      return bl;
   endfunction

   function automatic logic [DW-1:0] exp_mask(input int loc, input int len);
      logic [DW-1:0] m;
      m = '0;
      for (int i = 0; i < len; i++) m[(loc + i) % DW] = 1'b1;
      return m;
   endfunction

   // ready_mode: 0 always ready, 1 random, 2 hold low for 100 cycles on the first record.
   task automatic run_campaign(input int lf, input int ll, input int bl, input int fm, input int abort_after,
                               input int ready_mode, input int stray, output int got_total, output int got_eff);
      exp_t          expq[$];
      exp_t          e;
      int            len, nloc, nexp, neff, budget, t, last_t, recs, dones, stall, fe_cycles;
      logic          pending;
      logic [LW-1:0] s_loc;
      logic [HW-1:0] s_hd;
      logic [CW-1:0] s_tot;
      logic [DW-1:0] s_gold, s_faulty, gold_v;

      len  = clamp_len(bl);
      nloc = ((ll - lf + DW) % DW) + 1;
      nexp = (abort_after >= 0 && abort_after < nloc) ? abort_after + 1 : nloc;
      for (int k = 0; k < nexp; k++) begin
         e.loc  = LW'((lf + k) % DW);
         e.mask = exp_mask((lf + k) % DW, len);
         expq.push_back(e);
      end
      neff       = (fm != 0) ? nexp : 0;
      core_fault = (fm != 0);
      gold_v     = {$urandom, $urandom, $urandom, $urandom};
      core_const = gold_v;
      loc_first  = LW'(lf);
      loc_last   = LW'(ll);
      burst_len  = 4'(bl);
      res_ready  = 1'b1;
      abort      = 1'b0;
      start      = 1'b1;
      tick();
      start = 1'b0;
      check("busy after start", busy, 1);

      budget = nexp * 60 + 400;
      t = 0; last_t = 0; recs = 0; dones = 0; stall = 0; fe_cycles = 0; pending = 1'b0;
      while (dones == 0 && t < budget) begin
         if (fault_en) begin
            fe_cycles++;
            if (expq.size() > 0) check("fault mask", fault_mask, expq[0].mask);
         end else begin
            check("mask zero without fault", fault_mask, 0);
         end
         case (ready_mode)
            0:       res_ready = 1'b1;
            1:       res_ready = 1'($urandom_range(0, 1));
            default: res_ready = (stall >= 100);
         endcase
         if (res_valid) begin
            if (expq.size() == 0) begin
               check("record expected", expq.size(), 1);
            end else if (!pending) begin
               check("res_loc", res_loc, expq[0].loc);
               check("res_gold", res_gold, gold_v);
               check("res_faulty", res_faulty, (fm != 0) ? (gold_v ^ expq[0].mask) : gold_v);
               check("res_hd", res_hd, (fm != 0) ? $countones(expq[0].mask) : 0);
               check("fault off in report", fault_en, 0);
               check("fault_en run length", fe_cycles, LAT + 1);
               check("n_total running", n_total, recs);
               if (ready_mode == 0) begin
                  if (recs == 0) check("first record latency", t, 2 * (LAT + 1));
                  else           check("record period", t - last_t, 2 * (LAT + 1) + 2);
               end
               last_t    = t;
               fe_cycles = 0;
            end else begin
               check("stall hold", (res_loc == s_loc && res_hd == s_hd && n_total == s_tot &&
                                    res_gold == s_gold && res_faulty == s_faulty), 1);
            end
            if (res_ready) begin
               if (recs == abort_after) abort = 1'b1;
               if (expq.size() > 0) void'(expq.pop_front());
               recs++;
               pending = 1'b0;
            end else begin
               pending  = 1'b1;
               s_loc    = res_loc;
               s_hd     = res_hd;
               s_tot    = n_total;
               s_gold   = res_gold;
               s_faulty = res_faulty;
               if (recs == 0) stall++;
            end
         end
         if (done) dones++;
         start = (stray != 0 && t == 100);
         if (dones == 0) begin
            tick();
            t++;
         end
      end
      start = 1'b0;
      check("done within budget", dones, 1);
      check("records outstanding", expq.size(), 0);
      check("n_total", n_total, nexp);
      check("n_effective", n_effective, neff);
      got_total = int'(n_total);
      got_eff   = int'(n_effective);
      abort = 1'b0;
      tick();
      check("idle after done", {busy, done}, 0);
   endtask

   task automatic reset_mid_fault();
      int w;
      loc_first  = 7'd20;
      loc_last   = 7'd30;
      burst_len  = 4'd3;
      res_ready  = 1'b1;
      abort      = 1'b0;
      core_fault = 1'b1;
      core_const = '1;
      start = 1'b1;
      tick();
      start = 1'b0;
      w = 0;
      while (!(n_total == 1 && fault_en) && w < 400) begin
         tick();
         w++;
      end
      check("reached second faulted run", n_total, 1);
      repeat (5) tick();
      check("fault_en before reset", fault_en, 1);
      #2 rst_n = 1'b0;
      #1;
      check("reset fault_en", fault_en, 0);
      check("reset fault_mask", fault_mask, 0);
      check("reset busy", busy, 0);
      check("reset n_total", n_total, 0);
      check("reset n_effective", n_effective, 0);
      check("reset res_valid/core_start", {res_valid, core_start}, 0);
      @(negedge clk) rst_n = 1'b1;
      tick();
   endtask

   initial begin
      vec_t vecs[8];
      int   gt, ge;

      vecs[0] = '{0,   127, 1,  1, -1, 0, 0, 128, 128};
      vecs[1] = '{126, 1,   4,  1, -1, 0, 0, 4,   4};
      vecs[2] = '{0,   15,  2,  0, -1, 1, 0, 16,  0};
      vecs[3] = '{5,   7,   3,  1, -1, 2, 0, 3,   3};
      vecs[4] = '{0,   127, 1,  1, 10, 0, 1, 11,  11};
      vecs[5] = '{40,  42,  0,  1, -1, 0, 0, 3,   3};
      vecs[6] = '{100, 103, 15, 1, -1, 1, 0, 4,   4};
      vecs[7] = '{127, 127, 8,  1, -1, 0, 0, 1,   1};

      rst_n = 1'b0; start = 1'b0; abort = 1'b0; res_ready = 1'b1;
      burst_len = 4'd1; loc_first = '0; loc_last = '0;
      core_fault = 1'b0; core_const = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset status", {busy, done, core_start, fault_en, res_valid}, 0);
      check("reset fault_mask", fault_mask, 0);
      check("reset res_loc/res_hd", {res_loc, res_hd}, 0);
      check("reset res_gold", res_gold, 0);
      check("reset res_faulty", res_faulty, 0);
      check("reset counters", {n_total, n_effective}, 0);
      @(negedge clk) rst_n = 1'b1;
      tick();

      abort = 1'b1;
      repeat (3) tick();
      check("abort in idle", busy, 0);
      abort = 1'b0;

      for (int i = 0; i < 8; i++) begin
         if (i == 5) reset_mid_fault();
         run_campaign(vecs[i].lf, vecs[i].ll, vecs[i].bl, vecs[i].fm, vecs[i].abort_after,
                      vecs[i].ready_mode, vecs[i].stray, gt, ge);
         check("table n_total", gt, vecs[i].exp_total);
         check("table n_effective", ge, vecs[i].exp_eff);
      end

      for (int r = 0; r < 6; r++) begin
         int lf, span, ab;
         lf   = int'($urandom_range(0, 127));
         span = int'($urandom_range(0, 5));
         ab   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, span)) : -1;
         run_campaign(lf, (lf + span) % DW, int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
                      ab, int'($urandom_range(0, 1)), 0, gt, ge);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
